// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle between two memory masters (A = CPU, B = DMA /
//                loader), the two-port arbiter and a 64K x 8 synchronous
//                memory. The arbiter uses the slave view. The surrounding
//                system (masters plus memory) uses the master view.
//  Signals     : REQ_x / WE_x / ADDR_x / WDATA_x  request from master x
//                GNT_x                           combinational grant to x
//                RVALID_x / RDATA_x              read return to x
//                MEM_WE / MEM_ADDR / MEM_DIN     arbiter -> memory
//                MEM_DOUT                        memory -> arbiter
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // Port A (CPU)
    logic              REQ_A;
    logic              WE_A;
    logic [ADDR_W-1:0] ADDR_A;
    logic [DATA_W-1:0] WDATA_A;
    logic              GNT_A;
    logic              RVALID_A;
    logic [DATA_W-1:0] RDATA_A;

    // Port B (secondary master)
    logic              REQ_B;
    logic              WE_B;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] WDATA_B;
    logic              GNT_B;
    logic              RVALID_B;
    logic [DATA_W-1:0] RDATA_B;

    // Memory side
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DIN;
    logic [DATA_W-1:0] MEM_DOUT;

    modport slave (
        input  REQ_A, WE_A, ADDR_A, WDATA_A,
        input  REQ_B, WE_B, ADDR_B, WDATA_B,
        input  MEM_DOUT,
        output GNT_A, RVALID_A, RDATA_A,
        output GNT_B, RVALID_B, RDATA_B,
        output MEM_WE, MEM_ADDR, MEM_DIN
    );

    modport master (
        output REQ_A, WE_A, ADDR_A, WDATA_A,
        output REQ_B, WE_B, ADDR_B, WDATA_B,
        output MEM_DOUT,
        input  GNT_A, RVALID_A, RDATA_A,
        input  GNT_B, RVALID_B, RDATA_B,
        input  MEM_WE, MEM_ADDR, MEM_DIN
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter in front of a 64K x 8 synchronous memory
//                (single write port, registered read, 1-cycle latency).
//                At most one access is issued per cycle. A read returns its
//                data one cycle later, flagged by RVALID on the issuing port.
//  Parameters  : PRIORITY_MODE 0 = fixed priority to A with a starvation
//                              guard for B, 1 = round-robin
//                MAX_WAIT      mode 0: denied B cycles before B is forced
//                              (1..255)
//                ADDR_W/DATA_W address / data width
//  Ports       : CLK      clock, rising edge
//                RESET_N  asynchronous active-low reset
//                bus      mem_arbiter_if.slave (both masters + memory)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 4,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    mem_arbiter_if.slave bus
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    // Which port held the most recent grant (round-robin history).
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t             r_last;
    last_t             w_last_nxt;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_nxt;
    logic              r_rvalid_a;
    logic              r_rvalid_b;

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_b_wins_tie;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;

    // ------------------------------------------------------------------
    // Grant selection. No grant while reset is asserted, so nothing can
    // reach the memory during reset even though the outputs are
    // combinational.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_a      = 1'b0;
        w_gnt_b      = 1'b0;
        w_b_wins_tie = (PRIORITY_MODE == 0) ? (r_wait_cnt == c_MAX_WAIT)
                                            : (r_last == LAST_A);
        if (RESET_N) begin
            if (bus.REQ_A && bus.REQ_B) begin
                w_gnt_b = w_b_wins_tie;
                w_gnt_a = !w_b_wins_tie;
            end else begin
                w_gnt_a = bus.REQ_A;
                w_gnt_b = bus.REQ_B;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: last-grant history and B starvation counter.
    // ------------------------------------------------------------------
    always_comb begin
        w_last_nxt = r_last;
        w_wait_nxt = r_wait_cnt;
        if (w_gnt_a) begin
            w_last_nxt = LAST_A;
        end else if (w_gnt_b) begin
            w_last_nxt = LAST_B;
        end
        if (!bus.REQ_B || w_gnt_b) begin
            w_wait_nxt = 8'd0;
        end else if (r_wait_cnt < c_MAX_WAIT) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Memory request mux; an idle cycle drives all zeros (the resulting
    // read of address 0 is never flagged valid).
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_din  = '0;
        if (w_gnt_a) begin
            w_mem_we   = bus.WE_A;
            w_mem_addr = bus.ADDR_A;
            w_mem_din  = bus.WDATA_A;
        end else if (w_gnt_b) begin
            w_mem_we   = bus.WE_B;
            w_mem_addr = bus.ADDR_B;
            w_mem_din  = bus.WDATA_B;
        end
    end

    // ------------------------------------------------------------------
    // State registers. The read tags line up with the memory's one-cycle
    // registered read, so RVALID and MEM_DOUT are valid in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last     <= LAST_B;
            r_wait_cnt <= 8'd0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_last     <= w_last_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_rvalid_a <= w_gnt_a && !bus.WE_A;
            r_rvalid_b <= w_gnt_b && !bus.WE_B;
        end
    end

    assign bus.GNT_A    = w_gnt_a;
    assign bus.GNT_B    = w_gnt_b;
    assign bus.MEM_WE   = w_mem_we;
    assign bus.MEM_ADDR = w_mem_addr;
    assign bus.MEM_DIN  = w_mem_din;
    assign bus.RVALID_A = r_rvalid_a;
    assign bus.RVALID_B = r_rvalid_b;
    assign bus.RDATA_A  = bus.MEM_DOUT;
    assign bus.RDATA_B  = bus.MEM_DOUT;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Three arbiter
//                configurations (mode 0 / MAX_WAIT 4, mode 1, mode 0 /
//                MAX_WAIT 1) see the same stimulus, each with its own
//                memory and its own behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int N_CFG  = 3;
    localparam int c_MODE [0:N_CFG-1] = '{0, 1, 0};
    localparam int c_MW   [0:N_CFG-1] = '{4, 4, 1};

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b1;
    logic        req_a   = 1'b0;
    logic        we_a    = 1'b0;
    logic [15:0] addr_a  = 16'h0;
    logic [7:0]  wdata_a = 8'h0;
    logic        req_b   = 1'b0;
    logic        we_b    = 1'b0;
    logic [15:0] addr_b  = 16'h0;
    logic [7:0]  wdata_b = 8'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        if (a == 32'h0037) return 8'hDD;
        if (a == 32'h0047) return 8'hEE;
        if (a == 32'h0304) return 8'hFF;
        return 8'((a * 13) ^ (a >> 8) ^ 8'hA5);
    endfunction

    // One call = inputs for the next clock cycle, applied just after the edge.
    task automatic drive(input logic ra, input logic wa, input logic [15:0] aa, input logic [7:0] da,
                         input logic rb, input logic wb, input logic [15:0] ab, input logic [7:0] db);
        @(posedge CLK);
        #1;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    endtask

    for (genvar k = 0; k < N_CFG; k++) begin : g_cfg
        localparam int MODE = c_MODE[k];
        localparam int MW   = c_MW[k];

        mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

        assign bus.REQ_A   = req_a;
        assign bus.WE_A    = we_a;
        assign bus.ADDR_A  = addr_a;
        assign bus.WDATA_A = wdata_a;
        assign bus.REQ_B   = req_b;
        assign bus.WE_B    = we_b;
        assign bus.ADDR_B  = addr_b;
        assign bus.WDATA_B = wdata_b;

        // Memory the arbiter actually talks to.
        logic [7:0] env_mem [0:65535];
        logic [7:0] env_dout;
        always @(posedge CLK) begin
            if (bus.MEM_WE) env_mem[bus.MEM_ADDR] <= bus.MEM_DIN;
            env_dout <= env_mem[bus.MEM_ADDR];
        end
        assign bus.MEM_DOUT = env_dout;

        mem_arbiter #(
            .PRIORITY_MODE(MODE),
            .MAX_WAIT     (MW),
            .ADDR_W       (ADDR_W),
            .DATA_W       (DATA_W)
        ) dut (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .bus    (bus)
        );

        // Reference model: who gets served this cycle, and what each
        // master should see back.
        logic [7:0] ref_mem [0:65535];
        int         ref_wait;
        bit         ref_last_b;
        bit         ref_rv_a;
        bit         ref_rv_b;
        logic [7:0] ref_rdata;

        initial begin
            for (int i = 0; i < 65536; i++) begin
                env_mem[i] = init_byte(i);
                ref_mem[i] = init_byte(i);
            end
        end

        // 0 = nobody, 1 = A, 2 = B
        function automatic int winner();
            if (!RESET_N) return 0;
            if (req_a && req_b) begin
                if (MODE == 0) return (ref_wait >= MW) ? 2 : 1;
                return ref_last_b ? 1 : 2;
            end
            if (req_a) return 1;
            if (req_b) return 2;
            return 0;
        endfunction

        always @(posedge CLK or negedge RESET_N) begin : b_model
            int g;
            if (!RESET_N) begin
                ref_wait   = 0;
                ref_last_b = 1'b1;
                ref_rv_a   = 1'b0;
                ref_rv_b   = 1'b0;
            end else begin
                g = winner();
                ref_rv_a = (g == 1) && !we_a;
                ref_rv_b = (g == 2) && !we_b;
                if (g == 1) begin
                    ref_rdata  = ref_mem[addr_a];
                    if (we_a) ref_mem[addr_a] = wdata_a;
                    ref_last_b = 1'b0;
                end else if (g == 2) begin
                    ref_rdata  = ref_mem[addr_b];
                    if (we_b) ref_mem[addr_b] = wdata_b;
                    ref_last_b = 1'b1;
                end
                if (req_b && g != 2) ref_wait = (ref_wait < MW) ? ref_wait + 1 : MW;
                else                 ref_wait = 0;
            end
        end

        always @(negedge CLK) begin : b_check
            int          g;
            logic        e_we;
            logic [15:0] e_addr;
            logic [7:0]  e_din;
            g      = winner();
            e_we   = 1'b0;
            e_addr = 16'h0;
            e_din  = 8'h0;
            if (g == 1) begin e_we = we_a; e_addr = addr_a; e_din = wdata_a; end
            if (g == 2) begin e_we = we_b; e_addr = addr_b; e_din = wdata_b; end
            chk($sformatf("c%0d_gnt", k), {30'b0, bus.GNT_A, bus.GNT_B},
                {30'b0, (g == 1), (g == 2)});
            chk($sformatf("c%0d_membus", k), {7'b0, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN},
                {7'b0, e_we, e_addr, e_din});
            chk($sformatf("c%0d_rvalid", k), {30'b0, bus.RVALID_A, bus.RVALID_B},
                {30'b0, ref_rv_a, ref_rv_b});
            if (ref_rv_a) chk($sformatf("c%0d_rdata_a", k), {24'b0, bus.RDATA_A}, {24'b0, ref_rdata});
            if (ref_rv_b) chk($sformatf("c%0d_rdata_b", k), {24'b0, bus.RDATA_B}, {24'b0, ref_rdata});
        end
    end

    initial begin
        // Reset with both requests up: no grant may leak out.
        #1;
        RESET_N = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        @(negedge CLK);
        chk("rst_gnt0", {30'b0, g_cfg[0].bus.GNT_A, g_cfg[0].bus.GNT_B}, 32'd0);
        chk("rst_rv0", {30'b0, g_cfg[0].bus.RVALID_A, g_cfg[0].bus.RVALID_B}, 32'd0);
        chk("rst_memwe", {31'b0, g_cfg[1].bus.MEM_WE}, 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        req_a = 1'b0; req_b = 1'b0;

        // Single port: A writes 5A to 0200, then reads it back.
        drive(1, 1, 16'h0200, 8'h5A, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 16'h0200, 8'h00, 0, 0, 16'h0, 8'h0);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0, 8'h0);
        @(negedge CLK);
        chk("sp_rvalid", {30'b0, g_cfg[0].bus.RVALID_A, g_cfg[0].bus.RVALID_B}, 32'd2);
        chk("sp_rdata", {24'b0, g_cfg[0].bus.RDATA_A}, 32'h5A);

        // Continuous dual reads: fixed-priority and round-robin patterns.
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 16'h0037, 8'h00, 1, 0, 16'h0047, 8'h00);
            @(negedge CLK);
            chk("p_mw4", {31'b0, g_cfg[0].bus.GNT_B}, {31'b0, (i % 5) == 4});
            chk("p_rr", {31'b0, g_cfg[1].bus.GNT_A}, {31'b0, (i % 2) == 1});
            chk("p_mw1", {31'b0, g_cfg[2].bus.GNT_B}, {31'b0, (i % 2) == 1});
            if (g_cfg[1].bus.RVALID_A) chk("rr_dd", {24'b0, g_cfg[1].bus.RDATA_A}, 32'hDD);
            if (g_cfg[1].bus.RVALID_B) chk("rr_ee", {24'b0, g_cfg[1].bus.RDATA_B}, 32'hEE);
        end

        // Write suppression then readback on B.
        drive(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0304, 8'h33);
        drive(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0304, 8'h00);
        @(negedge CLK);
        chk("ws_norv", {31'b0, g_cfg[0].bus.RVALID_B}, 32'd0);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        @(negedge CLK);
        chk("ws_rv", {31'b0, g_cfg[0].bus.RVALID_B}, 32'd1);
        chk("ws_data", {24'b0, g_cfg[0].bus.RDATA_B}, 32'h33);

        // Idle stretch.
        repeat (10) @(posedge CLK);

        // Randomized traffic over a small address window so reads hit
        // recent writes.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, 16'h0200 + 16'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom % 3) != 0, $urandom % 2, 16'h0200 + 16'($urandom_range(0, 7)), 8'($urandom));
        end
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);

        // Reset while a read is being granted: it must never complete.
        drive(1, 0, 16'h0210, 8'h00, 0, 0, 16'h0000, 8'h00);
        @(negedge CLK); #1;
        RESET_N = 1'b0;
        req_a = 1'b0;
        @(posedge CLK); #1;
        chk("mr_rv_in_rst", {31'b0, g_cfg[0].bus.RVALID_A}, 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("mr_rv_after", {31'b0, g_cfg[0].bus.RVALID_A}, 32'd0);
        drive(1, 0, 16'h0037, 8'h00, 1, 0, 16'h0047, 8'h00);
        @(negedge CLK);
        chk("mr_rr_first", {30'b0, g_cfg[1].bus.GNT_A, g_cfg[1].bus.GNT_B}, 32'd2);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        repeat (3) @(negedge CLK);

        // Final memory contents must match the model.
        for (int i = 0; i < 1024; i++) begin
            chk("mem0", {24'b0, g_cfg[0].env_mem[i]}, {24'b0, g_cfg[0].ref_mem[i]});
            chk("mem1", {24'b0, g_cfg[1].env_mem[i]}, {24'b0, g_cfg[1].ref_mem[i]});
            chk("mem2", {24'b0, g_cfg[2].env_mem[i]}, {24'b0, g_cfg[2].ref_mem[i]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter in front of the 64K x 8 synchronous memory (one write port, registered read, 1-cycle read latency).
- Port A is the CPU; port B is the secondary master (DMA/loader).
- Each cycle the arbiter selects at most one access, drives the memory address/write/data, and returns read data to the issuing port one cycle later with a valid strobe.
- Sits between the CPU core and the memory; the CPU no longer drives the memory directly.

Parameters:
- PRIORITY_MODE, 0: 0 = fixed priority to A with starvation guard for B; 1 = round-robin.
- MAX_WAIT, 4: mode 0 only; consecutive denied request cycles for B before B is forced a grant (legal range 1..255).
- ADDR_W, 16: address width.
- DATA_W, 8: data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_A  in  1  port A access request; held until granted.
- WE_A  in  1  port A write (1) / read (0).
- ADDR_A  in  ADDR_W  port A address.
- WDATA_A  in  DATA_W  port A write data.
- GNT_A  out  1  combinational; access performed at this edge.
- RVALID_A  out  1  registered; read data valid for port A.
- RDATA_A  out  DATA_W  read data for port A.
- REQ_B, WE_B, ADDR_B, WDATA_B, GNT_B, RVALID_B, RDATA_B: same as port A, for port B.
- MEM_WE  out  1  to memory WE.
- MEM_ADDR  out  ADDR_W  to memory Address.
- MEM_DIN  out  DATA_W  to memory DataIn.
- MEM_DOUT  in  DATA_W  from memory DataOut.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - RVALID_A = RVALID_B = 0.
  - Wait counter = 0, last-grant = B (so A wins the first round-robin tie), read-pending tag cleared.
  - GNT_A = GNT_B = 0 while reset is asserted.
- Grant logic is combinational from REQ_A, REQ_B and registered state; GNT_A and GNT_B are never both 1.
  - Only one request asserted: that port is granted.
  - Neither asserted: no grant; MEM_WE=0, MEM_ADDR=0, MEM_DIN=0. The memory read of address 0 is ignored.
- Mode 0 with both requesting: A is granted unless the wait counter equals MAX_WAIT, in which case B is granted.
  - Wait counter increments each cycle that B requests and is not granted, saturating at MAX_WAIT.
  - It clears on any B grant or on any cycle with REQ_B=0.
- Mode 1 with both requesting: the port not granted in the most recent granted cycle wins.
  - Last-grant register updates only on cycles with a grant.
- Granted cycle:
  - MEM_WE = WE_x.
  - MEM_ADDR = ADDR_x.
  - MEM_DIN = WDATA_x.
  - The write commits at this rising edge.
- Read latency:
  - A granted read (WE_x=0) sets RVALID_x=1 in the following cycle; only the port that was granted is flagged.
  - RDATA_A = RDATA_B = MEM_DOUT as a pass-through, meaningful only while the matching RVALID is 1.
  - Back-to-back reads, including alternating A/B, give RVALID every cycle with correct routing.
- Writes produce no RVALID. The memory returns old data on a write cycle, and the arbiter discards it.
- Read after write to the same address in the next cycle returns the new data.
- A requester must hold REQ/WE/ADDR/WDATA stable until GNT. Deasserting REQ before grant cancels the request with no side effects.
- Reset mid-operation: a read granted in the cycle before reset produces no RVALID after reset releases.
- MAX_WAIT=1 in mode 0 under continuous dual requests gives alternating grants B, A, B, A... after the first A grant.

Test Plan:
- Single port: A writes 8'h5A to 16'h0200, then reads 16'h0200 → GNT_A each cycle; RVALID_A=1 one cycle after the read grant with RDATA_A=8'h5A; RVALID_B stays 0.
- Mode 0, MAX_WAIT=4, REQ_A and REQ_B held high continuously → grant pattern A,A,A,A,B repeating; each B grant has wait counter = 4; no cycle has both grants.
- Mode 1, both ports reading continuously (A at 16'h0037, B at 16'h0047, memory preloaded with 8'hDD and 8'hEE) → grants alternate A,B,A,B; RVALID alternates A,B one cycle later with RDATA 8'hDD and 8'hEE respectively.
- Write suppression: B writes 8'h33 to 16'h0304 (old value 8'hFF) → RVALID_B stays 0; the next B read of 16'h0304 returns 8'h33.
- Idle: both REQ=0 for 10 cycles → MEM_WE=0, MEM_ADDR=16'h0000, no RVALID; memory contents unchanged.
- Reset mid-read: A read granted, RESET_N pulled low before the next edge → RVALID_A remains 0 through and after reset; the first post-reset tie in mode 1 is granted to A.
